// File: rtl/mips_fetch_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mips_fetch_stage
// Description : Instruction-fetch stage with IF/ID pipeline register.
//               Owns the word-addressed PC and drives a synchronous
//               instruction memory with one cycle of read latency. A skid
//               register captures a read that returns while the stage is
//               stalled, so that no fetched instruction is ever lost.
// Ports       : clk, rst (sync, active-low)
//               stall, branch_taken, branch_target  - control from hazard/EX
//               imem_en, imem_addr, imem_rdata      - instruction memory
//               ifid_valid, ifid_instr, ifid_pc,
//               ifid_pc_plus1                       - IF/ID to decode
// Revision    : 1.0 - initial release
// ============================================================================
module mips_fetch_stage #(
    parameter int              PC_W     = 10,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter logic [31:0]     NOP      = 32'h0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    output logic            imem_en,
    output logic [PC_W-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    output logic            ifid_valid,
    output logic [31:0]     ifid_instr,
    output logic [PC_W-1:0] ifid_pc,
    output logic [PC_W-1:0] ifid_pc_plus1
);

    localparam logic [PC_W-1:0] c_pc_one = {{(PC_W-1){1'b0}}, 1'b1};

    logic [PC_W-1:0] r_fetch_pc;
    logic            r_inflight_v;
    logic [PC_W-1:0] r_inflight_pc;
    logic            r_skid_v;
    logic [31:0]     r_skid_instr;
    logic [PC_W-1:0] r_skid_pc;
    logic            r_ifid_valid;
    logic [31:0]     r_ifid_instr;
    logic [PC_W-1:0] r_ifid_pc;
    logic [PC_W-1:0] r_ifid_pc_plus1;

    // A read is only strobed on cycles that will actually advance; during
    // a stall or redirect the address would be thrown away anyway.
    assign imem_en   = rst & ~stall & ~branch_taken;
    assign imem_addr = r_fetch_pc;

    assign ifid_valid    = r_ifid_valid;
    assign ifid_instr    = r_ifid_instr;
    assign ifid_pc       = r_ifid_pc;
    assign ifid_pc_plus1 = r_ifid_pc_plus1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_fetch_pc      <= RESET_PC;
            r_inflight_v    <= 1'b0;
            r_inflight_pc   <= '0;
            r_skid_v        <= 1'b0;
            r_skid_instr    <= NOP;
            r_skid_pc       <= '0;
            r_ifid_valid    <= 1'b0;
            r_ifid_instr    <= NOP;
            r_ifid_pc       <= '0;
            r_ifid_pc_plus1 <= '0;
        end else if (branch_taken) begin
            // Squash everything younger than the branch; the PC fields of
            // IF/ID simply hold their last (defined) values.
            r_fetch_pc   <= branch_target;
            r_inflight_v <= 1'b0;
            r_skid_v     <= 1'b0;
            r_ifid_valid <= 1'b0;
            r_ifid_instr <= NOP;
        end else if (stall) begin
            // The read strobed last cycle returns now; park it in the skid
            // so it is presented first when the stall releases.
            if (r_inflight_v && !r_skid_v) begin
                r_skid_v     <= 1'b1;
                r_skid_instr <= imem_rdata;
                r_skid_pc    <= r_inflight_pc;
            end
            r_inflight_v <= 1'b0;
        end else begin
            // The skid is always older than anything in flight, so it wins.
            if (r_skid_v) begin
                r_ifid_valid    <= 1'b1;
                r_ifid_instr    <= r_skid_instr;
                r_ifid_pc       <= r_skid_pc;
                r_ifid_pc_plus1 <= r_skid_pc + c_pc_one;
                r_skid_v        <= 1'b0;
            end else if (r_inflight_v) begin
                r_ifid_valid    <= 1'b1;
                r_ifid_instr    <= imem_rdata;
                r_ifid_pc       <= r_inflight_pc;
                r_ifid_pc_plus1 <= r_inflight_pc + c_pc_one;
            end else begin
                r_ifid_valid <= 1'b0;
                r_ifid_instr <= NOP;
            end
            r_inflight_v  <= 1'b1;
            r_inflight_pc <= r_fetch_pc;
            r_fetch_pc    <= r_fetch_pc + c_pc_one;
        end
    end

endmodule
`default_nettype wire
